reset_release_sequencer: RTL and testbench
==========================================

Name: reset_release_sequencer

Overview:
Reset generator that drives per-block active-low resets for downstream logic such as the 8-bit counters. The external reset asserts all outputs asynchronously. Release is synchronized to clk, held for a programmable count, and then staged one domain at a time. A synchronous soft-reset request re-runs the hold and staging sequence without external reset.

Parameters:
SYNC_STAGES, 2, depth of rst_n release synchronizer (legal range 2..4)
HOLD_CYCLES, 8, cycles all stages stay in reset after synchronized release (legal range 1..255)
NUM_STAGES, 4, number of staged reset outputs (legal range 1..8)
STAGE_GAP, 3, cycles between consecutive stage releases (legal range 1..255)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
soft_rst_req  input  1  synchronous single-cycle soft-reset request
stage_rst_n  output  NUM_STAGES  staged active-low resets; bit 0 released first
rst_done  output  1  high once every stage is released
busy  output  1  high while the sequence is in progress
hold_cnt  output  8  current hold down-counter value

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values (on rst_n low, immediately, no clock needed):
  - synchronizer chain all 0; state=RESET
  - stage_rst_n all 0; rst_done=0; busy=1
  - hold_cnt=HOLD_CYCLES[7:0]
- Synchronizer: a SYNC_STAGES-flop chain shifts in 1; its last flop is sync_ok. Assertion is asynchronous; deassertion is seen after SYNC_STAGES rising edges. All outputs are registered. There is no combinational path from rst_n to any output except the async clear.
- States: RESET, HOLD, RELEASE, DONE.
  - RESET: when sync_ok=1, move to HOLD at the next edge; hold_cnt stays HOLD_CYCLES.
  - HOLD: each edge decrements hold_cnt. At an edge where hold_cnt==1: hold_cnt goes to 0, stage_rst_n[0] goes to 1, the internal stage index goes to 1, the gap counter loads STAGE_GAP, and the state moves to RELEASE. HOLD therefore lasts exactly HOLD_CYCLES cycles.
  - RELEASE: the gap counter decrements each edge. At an edge where it is 1, the next stage bit goes to 1 and the gap counter reloads. The edge after the last stage is released moves to DONE, with rst_done going to 1 and busy going to 0. hold_cnt stays 0.
  - DONE: all outputs are static until soft_rst_req or rst_n.
- Timing from the first edge where rst_n is sampled high (edge 1):
  - HOLD is entered at edge S+1.
  - stage i is released at edge S+H+1+i*G.
  - rst_done rises at edge S+H+2+(N-1)*G.
  - With defaults: stages at edges 11, 14, 17, 20; rst_done at edge 21.
- soft_rst_req, sampled high in HOLD, RELEASE or DONE:
  - At that edge, stage_rst_n goes to all 0, rst_done to 0, busy to 1, hold_cnt to HOLD_CYCLES, and the state to HOLD.
  - stage_rst_n[0] releases HOLD_CYCLES edges later.
  - In HOLD, a request re-arms the counter (restarts the full hold).
  - Ignored in RESET.
  - A held-high request keeps re-arming, so the sequence stays in HOLD.
- rst_n low at any point, including mid-HOLD or mid-RELEASE: immediate async clear to reset values. The full sequence restarts, synchronizer included.
  - A low pulse shorter than one clk period still causes the full restart.
- Ordering invariants:
  - stage_rst_n bits go 0->1 only at clk edges, strictly in index order, one per release event.
  - A higher bit is never 1 while a lower bit is 0.
  - rst_done=1 implies all stage_rst_n bits are 1.
  - busy equals NOT rst_done at all times.

Test Plan:
- Power-on, defaults, rst_n low for 12 ns then high (clk 10 ns period) -> all outputs at reset values while low; stage bits rise at edges 11, 14, 17, 20; rst_done=1 and busy=0 at edge 21; hold_cnt counts 8..1 then 0.
- rst_n pulsed low for 3 ns mid-RELEASE, after stage 1 is released -> stage_rst_n=0000 and rst_done=0 asynchronously; the full sequence restarts, with stage 0 at edge 11 after release.
- soft_rst_req one cycle in DONE at edge E -> stage_rst_n=0000 at E; stage 0 at E+8; stage 3 at E+17; rst_done at E+18.
- soft_rst_req in HOLD when hold_cnt=3 -> hold_cnt reloads to 8; stage 0 is released 8 edges after the request.
- soft_rst_req held high during RESET (before sync_ok) -> ignored; the sequence proceeds exactly as in the power-on case.
- Parameter sweep (NUM_STAGES=1, HOLD_CYCLES=1, STAGE_GAP=1, SYNC_STAGES=3) -> stage 0 at edge 5, rst_done at edge 6; ordering invariants hold throughout.

Source files
------------

// File: rtl/reset_release_sequencer.sv
// Reset generator: synchronizes rst_n release, holds every block in reset for
// HOLD_CYCLES, then releases NUM_STAGES active-low resets one every STAGE_GAP cycles.
module reset_release_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 8,
  parameter int NUM_STAGES  = 4,
  parameter int STAGE_GAP   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  soft_rst_req,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  rst_done,
  output logic                  busy,
  output logic [7:0]            hold_cnt
);

  typedef enum logic [1:0] {RESET, HOLD, RELEASE, DONE} state_e;

  localparam logic [7:0]            HOLD_INIT = 8'(HOLD_CYCLES);
  localparam logic [7:0]            GAP_INIT  = 8'(STAGE_GAP);
  localparam logic [NUM_STAGES-1:0] STAGE_ONE = NUM_STAGES'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_ok;
  state_e                 state_q, state_d;
  logic [NUM_STAGES-1:0]  stage_q, stage_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic [7:0]             hold_q, hold_d;
  logic [7:0]             gap_q, gap_d;

  assign sync_ok = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], 1'b1};
    state_d = state_q;
    stage_d = stage_q;
    done_d  = done_q;
    busy_d  = busy_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    // Soft request re-runs hold+staging from any state past the synchronizer.
    if (soft_rst_req && state_q != RESET) begin
      state_d = HOLD;
      stage_d = '0;
      done_d  = 1'b0;
      busy_d  = 1'b1;
      hold_d  = HOLD_INIT;
    end else begin
      case (state_q)
        RESET: if (sync_ok) state_d = HOLD;
        HOLD: begin
          if (hold_q == 8'd1) begin
            hold_d  = 8'd0;
            stage_d = STAGE_ONE;
            gap_d   = GAP_INIT;
            state_d = RELEASE;
          end else begin
            hold_d = hold_q - 8'd1;
          end
        end
        RELEASE: begin
          if (&stage_q) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else if (gap_q == 8'd1) begin
            // Thermometer fill keeps release strictly in index order.
            stage_d = (stage_q << 1) | STAGE_ONE;
            gap_d   = GAP_INIT;
          end else begin
            gap_d = gap_q - 8'd1;
          end
        end
        DONE: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= RESET;
      stage_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
      hold_q  <= HOLD_INIT;
      gap_q   <= GAP_INIT;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      stage_q <= stage_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
    end
  end

  assign stage_rst_n = stage_q;
  assign rst_done    = done_q;
  assign busy        = busy_q;
  assign hold_cnt    = hold_q;

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Scoreboard bench: a timeline model predicts each cycle's outputs for a default
// instance and a minimal-parameter instance; a negedge monitor compares them.
module tb_reset_release_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       soft_rst_req = 1'b0;

  logic [3:0] s0_stage;
  logic       s0_done, s0_busy;
  logic [7:0] s0_hold;
  logic [0:0] s1_stage;
  logic       s1_done, s1_busy;
  logic [7:0] s1_hold;

  int errs = 0;
  int checks = 0;

  reset_release_sequencer #(.SYNC_STAGES(2), .HOLD_CYCLES(8), .NUM_STAGES(4), .STAGE_GAP(3)) dut0 (
    .clk(clk), .rst_n(rst_n), .soft_rst_req(soft_rst_req),
    .stage_rst_n(s0_stage), .rst_done(s0_done), .busy(s0_busy), .hold_cnt(s0_hold));

  reset_release_sequencer #(.SYNC_STAGES(3), .HOLD_CYCLES(1), .NUM_STAGES(1), .STAGE_GAP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .soft_rst_req(soft_rst_req),
    .stage_rst_n(s1_stage), .rst_done(s1_done), .busy(s1_busy), .hold_cnt(s1_hold));

  always #5 clk = ~clk;

  function automatic int p_s(input int j); return (j == 0) ? 2 : 3; endfunction
  function automatic int p_h(input int j); return (j == 0) ? 8 : 1; endfunction
  function automatic int p_n(input int j); return (j == 0) ? 4 : 1; endfunction
  function automatic int p_g(input int j); return (j == 0) ? 3 : 1; endfunction

  // Expected {stage[7:0], done, busy, hold[7:0]}; k counts edges since the hold was loaded.
  function automatic logic [17:0] expect_out(input bit anch, input int k, input int j);
    int h, g, n, hold, rel;
    logic [7:0] stg;
    logic done;
    h = p_h(j); g = p_g(j); n = p_n(j);
    if (!anch) return {8'h00, 1'b0, 1'b1, 8'(h)};
    hold = (k < h) ? h - k : 0;
    rel  = (k < h) ? 0 : (k - h) / g + 1;
    if (rel > n) rel = n;
    stg  = 8'((1 << rel) - 1);
    done = (k >= h + (n - 1) * g + 1);
    return {stg, done, ~done, 8'(hold)};
  endfunction

  bit anch[2];
  int cnt[2];
  int kk[2];
  logic [17:0] q0[$];
  logic [17:0] q1[$];

  task automatic step(input int j);
    if (!rst_n) begin
      anch[j] = 1'b0; cnt[j] = 0;
    end else if (!anch[j]) begin
      cnt[j]++;
      if (cnt[j] == p_s(j) + 1) begin anch[j] = 1'b1; kk[j] = 0; end
    end else if (soft_rst_req) begin
      kk[j] = 0;
    end else if (kk[j] < 100000) begin
      kk[j]++;
    end
  endtask

  always @(posedge clk) begin
    step(0);
    step(1);
    q0.push_back(expect_out(anch[0], kk[0], 0));
    q1.push_back(expect_out(anch[1], kk[1], 1));
  end

  // Async clear replaces whatever this cycle was predicted to show.
  always @(negedge rst_n) begin
    if ($time > 0) begin
      anch[0] = 1'b0; cnt[0] = 0;
      anch[1] = 1'b0; cnt[1] = 0;
      q0.delete(); q0.push_back(expect_out(1'b0, 0, 0));
      q1.delete(); q1.push_back(expect_out(1'b0, 0, 1));
    end
  end

  function automatic logic [17:0] obs(input int j);
    if (j == 0) return {4'h0, s0_stage, s0_done, s0_busy, s0_hold};
    return {7'h00, s1_stage, s1_done, s1_busy, s1_hold};
  endfunction

  task automatic compare(input string tag, input int j, input logic [17:0] got, input logic [17:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s dut%0d t=%0t: got stage=%b done=%b busy=%b hold=%0d, want stage=%b done=%b busy=%b hold=%0d",
               tag, j, $time, got[17:10], got[9], got[8], got[7:0], want[17:10], want[9], want[8], want[7:0]);
    end
  endtask

  always @(negedge clk) begin
    if (q0.size() == 0) begin
      checks++; errs++; $display("FAIL queue0 t=%0t: got empty, want one entry", $time);
    end else compare("cycle", 0, obs(0), q0.pop_front());
    if (q1.size() == 0) begin
      checks++; errs++; $display("FAIL queue1 t=%0t: got empty, want one entry", $time);
    end else compare("cycle", 1, obs(1), q1.pop_front());
  end

  task automatic tick(input logic s);
    @(posedge clk);
    #2 soft_rst_req = s;
  endtask

  // Short low pulse well inside one clock period; outputs must clear with no edge.
  task automatic pulse(input int w);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    compare("async", 0, obs(0), expect_out(1'b0, 0, 0));
    compare("async", 1, obs(1), expect_out(1'b0, 0, 1));
    #(w) rst_n = 1'b1;
  endtask

  initial begin
    #12 rst_n = 1'b1;
    repeat (30) tick(1'b0);
    // single request in DONE
    tick(1'b1);
    repeat (25) tick(1'b0);
    // request, then a second one while dut0 shows hold_cnt=3
    tick(1'b1);
    repeat (5) tick(1'b0);
    tick(1'b1);
    repeat (25) tick(1'b0);
    // async pulse after dut0 stage 1 released
    tick(1'b1);
    repeat (13) tick(1'b0);
    pulse(2);
    repeat (30) tick(1'b0);
    // soft request held high through the synchronizer window
    tick(1'b1);
    pulse(2);
    tick(1'b1);
    tick(1'b1);
    repeat (30) tick(1'b0);
    // random mix of requests, held bursts and reset pulses
    repeat (300) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) pulse($urandom_range(1, 2));
      else if (r < 6) repeat (6) tick(1'b1);
      else tick($urandom_range(0, 7) == 0);
    end
    repeat (40) tick(1'b0);
    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
